// File: rtl/move_scheduler_if.sv
// Bus bundle between the move scheduler, the tick source, the shared wall LUT
// and the per-agent position registers.
//
// Handshake rules: tick is a one-cycle request with no ready signal. It is
// accepted on any edge where busy is low and is dropped (raising the sticky
// overrun flag) when busy is high. upd_valid is a one-cycle strobe that has
// no backpressure: the consumer must take upd_id/x/y/blocked in that cycle.
// The fields hold their value between strobes. map_q must answer the address
// on map_x/map_y in the cycle after that address first appears.
interface move_scheduler_if #(
  parameter int NUM_AGENTS = 4
);
  logic                      tick;
  logic [3*NUM_AGENTS-1:0]   agent_dir;
  logic [8*NUM_AGENTS-1:0]   agent_x;
  logic [7*NUM_AGENTS-1:0]   agent_y;
  logic [7:0]                map_x;
  logic [6:0]                map_y;
  logic                      map_q;
  logic                      upd_valid;
  logic [2:0]                upd_id;
  logic [7:0]                upd_x;
  logic [6:0]                upd_y;
  logic                      upd_blocked;
  logic                      busy;
  logic                      done;
  logic                      overrun;
  logic [1:0]                fsm_state;

  // Tick source, agent registers and wall LUT side.
  modport master (
    output tick, agent_dir, agent_x, agent_y, map_q,
    input  map_x, map_y, upd_valid, upd_id, upd_x, upd_y, upd_blocked,
           busy, done, overrun, fsm_state
  );

  // Scheduler side.
  modport slave (
    input  tick, agent_dir, agent_x, agent_y, map_q,
    output map_x, map_y, upd_valid, upd_id, upd_x, upd_y, upd_blocked,
           busy, done, overrun, fsm_state
  );
endinterface

// File: rtl/move_scheduler.sv
// Per-tick movement sequencer. Agents are visited in index order; each one
// takes two cycles (ADDR: wall LUT address out, EVAL: LUT answer in) and
// produces one committed position on the upd_* strobe.
module move_scheduler #(
  parameter int NUM_AGENTS = 4,
  parameter int X_MAX      = 26,
  parameter int Y_MAX      = 23
) (
  input  logic             clock,
  input  logic             reset_n,
  move_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  localparam logic [7:0] XM   = 8'(X_MAX);
  localparam logic [6:0] YM   = 7'(Y_MAX);
  localparam logic [2:0] LAST = 3'(NUM_AGENTS - 1);

  // Candidate column: only RIGHT and LEFT move horizontally.
  function automatic logic [7:0] cand_x(input logic [2:0] dir, input logic [7:0] x);
    logic [7:0] r;
    r = x;
    if (dir == 3'd0) r = (x == XM) ? 8'd0 : x + 8'd1;
    else if (dir == 3'd2) r = (x == 8'd0) ? XM : x - 8'd1;
    return r;
  endfunction

  // Candidate row: UP increments, DOWN decrements.
  function automatic logic [6:0] cand_y(input logic [2:0] dir, input logic [6:0] y);
    logic [6:0] r;
    r = y;
    if (dir == 3'd1) r = (y == YM) ? 7'd0 : y + 7'd1;
    else if (dir == 3'd3) r = (y == 7'd0) ? YM : y - 7'd1;
    return r;
  endfunction

  // A move across the screen edge always succeeds regardless of the map.
  function automatic logic is_wrap(input logic [2:0] dir, input logic [7:0] x,
                                   input logic [6:0] y);
    logic r;
    case (dir)
      3'd0:    r = (x == XM);
      3'd1:    r = (y == YM);
      3'd2:    r = (x == 8'd0);
      3'd3:    r = (y == 7'd0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t                    state, state_n;
  logic [2:0]                idx;
  logic [3*NUM_AGENTS-1:0]   snap_dir;
  logic [8*NUM_AGENTS-1:0]   snap_x;
  logic [7*NUM_AGENTS-1:0]   snap_y;

  logic [2:0]  cur_dir, nxt_dir;
  logic [7:0]  cur_x, nxt_x;
  logic [6:0]  cur_y, nxt_y;
  logic [7:0]  cur_cx;
  logic [6:0]  cur_cy;
  logic        cur_wrap, cur_hold, cur_blocked;
  logic        last;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state: IDLE waits for tick, then ADDR/EVAL alternate per agent.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.tick) state_n = S_ADDR;
      S_ADDR:  state_n = S_EVAL;
      S_EVAL:  state_n = last ? S_IDLE : S_ADDR;
      default: state_n = S_IDLE;
    endcase
  end

  // Select the current and following agent from the snapshot.
  always_comb begin
    cur_dir = '0;
    cur_x   = '0;
    cur_y   = '0;
    nxt_dir = '0;
    nxt_x   = '0;
    nxt_y   = '0;
    for (int k = 0; k < NUM_AGENTS; k++) begin
      if (idx == 3'(k)) begin
        cur_dir = snap_dir[3*k +: 3];
        cur_x   = snap_x[8*k +: 8];
        cur_y   = snap_y[7*k +: 7];
      end
      if (idx + 3'd1 == 3'(k)) begin
        nxt_dir = snap_dir[3*k +: 3];
        nxt_x   = snap_x[8*k +: 8];
        nxt_y   = snap_y[7*k +: 7];
      end
    end
  end

  // Commit decision for the agent under evaluation.
  always_comb begin
    last        = (idx == LAST);
    cur_cx      = cand_x(cur_dir, cur_x);
    cur_cy      = cand_y(cur_dir, cur_y);
    cur_wrap    = is_wrap(cur_dir, cur_x, cur_y);
    cur_hold    = cur_dir[2];
    cur_blocked = !cur_hold && !cur_wrap && bus.map_q;
  end

  // Datapath: snapshot on tick, LUT address, update strobe and sticky overrun.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx             <= '0;
      snap_dir        <= '0;
      snap_x          <= '0;
      snap_y          <= '0;
      bus.map_x       <= '0;
      bus.map_y       <= '0;
      bus.upd_valid   <= 1'b0;
      bus.upd_id      <= '0;
      bus.upd_x       <= '0;
      bus.upd_y       <= '0;
      bus.upd_blocked <= 1'b0;
      bus.done        <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.upd_valid <= 1'b0;
      bus.done      <= 1'b0;
      if (bus.tick && state != S_IDLE) bus.overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.tick) begin
            snap_dir  <= bus.agent_dir;
            snap_x    <= bus.agent_x;
            snap_y    <= bus.agent_y;
            idx       <= '0;
            // Agent 0's address goes out in the first ADDR cycle, so it is
            // taken from the inputs being snapshotted on this same edge.
            bus.map_x <= cand_x(bus.agent_dir[2:0], bus.agent_x[7:0]);
            bus.map_y <= cand_y(bus.agent_dir[2:0], bus.agent_y[6:0]);
          end
        end
        S_EVAL: begin
          bus.upd_valid   <= 1'b1;
          bus.upd_id      <= idx;
          bus.upd_x       <= cur_blocked ? cur_x : cur_cx;
          bus.upd_y       <= cur_blocked ? cur_y : cur_cy;
          bus.upd_blocked <= cur_blocked;
          bus.done        <= last;
          if (!last) begin
            idx       <= idx + 3'd1;
            bus.map_x <= cand_x(nxt_dir, nxt_x);
            bus.map_y <= cand_y(nxt_dir, nxt_y);
          end
        end
        default: ;
      endcase
    end
  end

  // Status views of the FSM.
  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.fsm_state = state;
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: a per-cycle reference model derived from the
// tick-relative timing and move rules, directed scenarios pinned with literal
// expectations, then randomized ticks, agents, wall maps and resets.
module tb_move_scheduler;
  localparam int N  = 4;
  localparam int XM = 26;
  localparam int YM = 23;
  localparam int MAP_SZ = (XM + 1) * (YM + 1);

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  move_scheduler_if #(.NUM_AGENTS(N)) bus();
  move_scheduler #(.NUM_AGENTS(N), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- wall LUT ----------------
  logic wall_mem [0:MAP_SZ-1];
  always_comb begin
    bus.map_q = 1'b0;
    if (bus.map_x <= 8'(XM) && bus.map_y <= 7'(YM))
      bus.map_q = wall_mem[int'(bus.map_y) * (XM + 1) + int'(bus.map_x)];
  end

  // ---------------- counters / logs ----------------
  int vectors     = 0;
  int miscompares = 0;
  int tick_cyc    = 0;
  bit log_en      = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] act_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] pk(input int off, input int id, input int x,
                                     input int y, input int b);
    return {5'(off), 3'(id), 8'(x), 7'(y), 1'(b)};
  endfunction

  // ---------------- reference model ----------------
  bit seq_act = 1'b0;
  int seq_t   = 0;
  int a_cx[N], a_cy[N], a_ux[N], a_uy[N], a_ub[N];
  int m_map_x = 0, m_map_y = 0, m_id = 0, m_ux = 0, m_uy = 0, m_ub = 0;
  int m_overrun = 0;

  task automatic model_agent(input int dir, input int x, input int y,
                             output int cx, output int cy,
                             output int ux, output int uy, output int ub);
    bit wrap;
    wrap = 1'b0;
    cx = x;
    cy = y;
    case (dir)
      0: if (x == XM) begin cx = 0;  wrap = 1'b1; end else cx = x + 1;
      1: if (y == YM) begin cy = 0;  wrap = 1'b1; end else cy = y + 1;
      2: if (x == 0)  begin cx = XM; wrap = 1'b1; end else cx = x - 1;
      3: if (y == 0)  begin cy = YM; wrap = 1'b1; end else cy = y - 1;
      default: ;
    endcase
    if (dir < 4 && !wrap && wall_mem[cy * (XM + 1) + cx] == 1'b1) begin
      ux = x; uy = y; ub = 1;
    end else begin
      ux = cx; uy = cy; ub = 0;
    end
  endtask

  // Compare DUT outputs with the model every cycle, then fold in this cycle's inputs.
  always @(negedge clock) begin
    int d, k;
    logic e_busy, e_valid, e_done;
    e_busy  = 1'b0;
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (seq_act) begin
      d = cyc - seq_t;
      e_busy = (d >= 1 && d <= 2 * N);
      if (d >= 1 && d <= 2 * N - 1 && d % 2 == 1) begin
        k = (d - 1) / 2;
        m_map_x = a_cx[k];
        m_map_y = a_cy[k];
      end
      if (d >= 3 && d <= 2 * N + 1 && d % 2 == 1) begin
        k = (d - 3) / 2;
        e_valid = 1'b1;
        e_done  = (k == N - 1);
        m_id = k;
        m_ux = a_ux[k];
        m_uy = a_uy[k];
        m_ub = a_ub[k];
      end
    end
    chk("busy",        32'(bus.busy),        32'(e_busy));
    chk("upd_valid",   32'(bus.upd_valid),   32'(e_valid));
    chk("done",        32'(bus.done),        32'(e_done));
    chk("map_x",       32'(bus.map_x),       m_map_x);
    chk("map_y",       32'(bus.map_y),       m_map_y);
    chk("upd_id",      32'(bus.upd_id),      m_id);
    chk("upd_x",       32'(bus.upd_x),       m_ux);
    chk("upd_y",       32'(bus.upd_y),       m_uy);
    chk("upd_blocked", 32'(bus.upd_blocked), m_ub);
    chk("overrun",     32'(bus.overrun),     m_overrun);
    if (log_en && bus.upd_valid === 1'b1)
      act_q.push_back({5'(cyc - tick_cyc), bus.upd_id, bus.upd_x, bus.upd_y, bus.upd_blocked});

    if (!reset_n) begin
      seq_act = 1'b0;
      m_map_x = 0; m_map_y = 0; m_id = 0; m_ux = 0; m_uy = 0; m_ub = 0;
      m_overrun = 0;
    end else if (bus.tick === 1'b1) begin
      if (!e_busy) begin
        seq_act = 1'b1;
        seq_t   = cyc;
        for (int j = 0; j < N; j++)
          model_agent(int'(bus.agent_dir[3*j +: 3]), int'(bus.agent_x[8*j +: 8]),
                      int'(bus.agent_y[7*j +: 7]),
                      a_cx[j], a_cy[j], a_ux[j], a_uy[j], a_ub[j]);
      end else begin
        m_overrun = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_agent(input int k, input int dir, input int x, input int y);
    bus.agent_dir[3*k +: 3] = 3'(dir);
    bus.agent_x[8*k +: 8]   = 8'(x);
    bus.agent_y[7*k +: 7]   = 7'(y);
  endtask

  // Drives tick for one cycle; returns in the cycle after the tick.
  task automatic pulse_tick(input bit mark);
    @(posedge clock); #1;
    bus.tick = 1'b1;
    if (mark) tick_cyc = cyc;
    @(posedge clock); #1;
    bus.tick = 1'b0;
  endtask

  task automatic fill_walls(input int pct);
    for (int i = 0; i < MAP_SZ; i++) wall_mem[i] = ($urandom_range(99) < pct);
  endtask

  task automatic start_log();
    act_q.delete();
    exp_q.delete();
    log_en = 1'b1;
  endtask

  task automatic check_log(input string name);
    vectors++;
    if (act_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s update count: got %0d want %0d", name, act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [23:0] e, a;
      e = exp_q.pop_front();
      vectors++;
      if (act_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s entry: got none want %h", name, e);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          miscompares++;
          $display("FAIL %s entry: got %h want %h", name, a, e);
        end
      end
    end
    act_q.delete();
    log_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.tick      = 1'b0;
    bus.agent_dir = '0;
    bus.agent_x   = '0;
    bus.agent_y   = '0;
    fill_walls(0);
    reset_n = 1'b0;
    wait_cycles(3);
    chk("reset map_x", 32'(bus.map_x), 32'd0);
    chk("reset upd_valid", 32'(bus.upd_valid), 32'd0);
    reset_n = 1'b1;
    wait_cycles(2);

    // Basic move right, remaining agents waiting.
    set_agent(0, 0, 2, 1);
    set_agent(1, 4, 5, 6);
    set_agent(2, 5, 10, 3);
    set_agent(3, 7, 20, 20);
    start_log();
    pulse_tick(1'b1);
    wait_cycles(12);
    exp_q.push_back(pk(3, 0, 3, 1, 0));
    exp_q.push_back(pk(5, 1, 5, 6, 0));
    exp_q.push_back(pk(7, 2, 10, 3, 0));
    exp_q.push_back(pk(9, 3, 20, 20, 0));
    check_log("right");

    // Move up into a wall at (2,2).
    wall_mem[2 * (XM + 1) + 2] = 1'b1;
    set_agent(0, 1, 2, 1);
    start_log();
    pulse_tick(1'b1);
    chk("wall map_x", 32'(bus.map_x), 32'd2);
    chk("wall map_y", 32'(bus.map_y), 32'd2);
    wait_cycles(11);
    exp_q.push_back(pk(3, 0, 2, 1, 1));
    exp_q.push_back(pk(5, 1, 5, 6, 0));
    exp_q.push_back(pk(7, 2, 10, 3, 0));
    exp_q.push_back(pk(9, 3, 20, 20, 0));
    check_log("wall");

    // Wraps on every edge with walls everywhere.
    fill_walls(100);
    set_agent(0, 0, 26, 5);
    set_agent(1, 2, 0, 5);
    set_agent(2, 1, 4, 23);
    set_agent(3, 3, 4, 0);
    start_log();
    pulse_tick(1'b1);
    wait_cycles(12);
    exp_q.push_back(pk(3, 0, 0, 5, 0));
    exp_q.push_back(pk(5, 1, 26, 5, 0));
    exp_q.push_back(pk(7, 2, 4, 0, 0));
    exp_q.push_back(pk(9, 3, 4, 23, 0));
    check_log("wrap");
    fill_walls(0);

    // WAIT direction and input changes after the tick.
    set_agent(0, 2, 5, 5);
    set_agent(1, 3, 7, 7);
    set_agent(2, 6, 10, 10);
    set_agent(3, 0, 1, 1);
    start_log();
    pulse_tick(1'b1);
    for (int k = 0; k < N; k++)
      set_agent(k, $urandom_range(7), $urandom_range(XM), $urandom_range(YM));
    wait_cycles(11);
    exp_q.push_back(pk(3, 0, 4, 5, 0));
    exp_q.push_back(pk(5, 1, 7, 6, 0));
    exp_q.push_back(pk(7, 2, 10, 10, 0));
    exp_q.push_back(pk(9, 3, 2, 1, 0));
    check_log("snapshot");

    // Tick while busy, then a tick in the done cycle.
    set_agent(0, 0, 2, 1);
    set_agent(1, 4, 5, 6);
    set_agent(2, 5, 10, 3);
    set_agent(3, 7, 20, 20);
    start_log();
    pulse_tick(1'b1);       // T, now in T+1
    wait_cycles(2);         // T+3
    pulse_tick(1'b0);       // tick at T+4, now in T+5
    wait_cycles(3);         // T+8
    pulse_tick(1'b0);       // tick at T+9, now in T+10
    wait_cycles(11);
    chk("overrun sticky", 32'(bus.overrun), 32'd1);
    exp_q.push_back(pk(3, 0, 3, 1, 0));
    exp_q.push_back(pk(5, 1, 5, 6, 0));
    exp_q.push_back(pk(7, 2, 10, 3, 0));
    exp_q.push_back(pk(9, 3, 20, 20, 0));
    exp_q.push_back(pk(12, 0, 3, 1, 0));
    exp_q.push_back(pk(14, 1, 5, 6, 0));
    exp_q.push_back(pk(16, 2, 10, 3, 0));
    exp_q.push_back(pk(18, 3, 20, 20, 0));
    check_log("overrun");

    // Reset in the middle of a sequence.
    start_log();
    pulse_tick(1'b1);       // now T+1
    wait_cycles(2);         // T+3
    reset_n = 1'b0;
    wait_cycles(1);         // T+4 reset asserted
    reset_n = 1'b1;
    wait_cycles(1);         // T+5
    chk("post reset busy",      32'(bus.busy),      32'd0);
    chk("post reset upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("post reset map_x",     32'(bus.map_x),     32'd0);
    chk("post reset upd_x",     32'(bus.upd_x),     32'd0);
    chk("post reset overrun",   32'(bus.overrun),   32'd0);
    wait_cycles(10);
    exp_q.push_back(pk(3, 0, 3, 1, 0));
    check_log("reset abort");
    start_log();
    pulse_tick(1'b1);
    wait_cycles(12);
    exp_q.push_back(pk(3, 0, 3, 1, 0));
    exp_q.push_back(pk(5, 1, 5, 6, 0));
    exp_q.push_back(pk(7, 2, 10, 3, 0));
    exp_q.push_back(pk(9, 3, 20, 20, 0));
    check_log("after reset");

    // Randomized traffic against the model.
    for (int it = 0; it < 250; it++) begin
      if (it % 25 == 0) begin
        wait_cycles(2 * N + 3);
        fill_walls($urandom_range(60));
      end
      for (int k = 0; k < N; k++) begin
        int x, y;
        x = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 0 : XM) : $urandom_range(XM);
        y = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 0 : YM) : $urandom_range(YM);
        set_agent(k, $urandom_range(7), x, y);
      end
      pulse_tick(1'b0);
      wait_cycles($urandom_range(12));
      if ($urandom_range(40) == 0) begin
        reset_n = 1'b0;
        wait_cycles(1);
        reset_n = 1'b1;
      end
    end
    wait_cycles(2 * N + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
Per-game-tick movement sequencer for all moving agents: agent 0 is pac-man, agents 1..NUM_AGENTS-1 are ghosts.
- Shares the single map lookup port (wall LUT) among the agents in fixed order, one agent at a time.
- For each agent, computes the candidate next tile with screen wrap, checks it against the map and emits the committed position on an update strobe.
- Sits between the game-tick generator and the per-agent position registers and renderers.

Parameters:
NUM_AGENTS, 4, number of agents serviced per tick (1..8); agent 0 is always serviced first.
X_MAX, 26, highest tile column; columns wrap between 0 and X_MAX.
Y_MAX, 23, highest tile row; rows wrap between 0 and Y_MAX.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset_n  in  1  synchronous, active-low reset.
tick  in  1  one-cycle game-step request.
agent_dir  in  3*NUM_AGENTS  direction per agent, agent k at bits [3k+2:3k]; 0=RIGHT, 1=UP, 2=LEFT, 3=DOWN, 4..7=WAIT.
agent_x  in  8*NUM_AGENTS  current column per agent, agent k at [8k+7:8k].
agent_y  in  7*NUM_AGENTS  current row per agent, agent k at [7k+6:7k].
map_x  out  8  lookup column (registered).
map_y  out  7  lookup row (registered).
map_q  in  1  wall flag for (map_x, map_y); 1 = wall; must be valid the cycle after the address is presented.
upd_valid  out  1  one-cycle strobe: upd_* fields hold a committed result.
upd_id  out  3  agent index of the current update.
upd_x  out  8  committed column.
upd_y  out  7  committed row.
upd_blocked  out  1  1 when a wall cancelled the move.
busy  out  1  high while a sequence is in progress.
done  out  1  one-cycle pulse with the last agent's upd_valid.
overrun  out  1  sticky; set when tick arrives while busy.

Behaviour:
- Reset (reset_n low at an edge): state IDLE, agent index 0, snapshots cleared. All outputs 0, including map_x/map_y and overrun. Reset takes effect mid-sequence too: no further upd_valid or done for the aborted tick.
- States:
  - IDLE: wait for tick. Leave IDLE when tick is high at an edge (cycle T). Then snapshot all agent_dir/x/y, set index=0 and go to ADDR.
  - ADDR: drive the candidate tile for agent[index] on map_x/map_y; go to EVAL.
  - EVAL: sample map_q at the end of this cycle and register the upd_* fields. If index=NUM_AGENTS-1, go to IDLE; otherwise increment index and go to ADDR.
- Candidate tile, computed from the snapshot only. Input changes after T are ignored until the next tick.
  - RIGHT: x==X_MAX ? 0 : x+1.
  - LEFT: x==0 ? X_MAX : x-1.
  - UP: y==Y_MAX ? 0 : y+1.
  - DOWN: y==0 ? Y_MAX : y-1.
  - WAIT (4..7): candidate = current tile.
- Commit rule:
  - Wrap move (a boundary case above): commit the candidate, map_q ignored, blocked=0.
  - WAIT: commit the current tile, blocked=0; the lookup is still issued for uniform timing.
  - Otherwise, map_q=1: commit the current tile, blocked=1.
  - Otherwise, map_q=0: commit the candidate, blocked=0.
- Timing for agent k: ADDR at T+1+2k, EVAL at T+2+2k, upd_valid high at T+3+2k for exactly one cycle. upd_id/x/y/blocked are valid only while upd_valid is high and hold their value otherwise.
- done is high at T+1+2*NUM_AGENTS, the same cycle as the last upd_valid.
- busy is high from T+1 through T+2*NUM_AGENTS inclusive, i.e. high in ADDR/EVAL and low in IDLE.
- A tick is accepted in any IDLE cycle, including the cycle in which done is high.
- A tick while busy is dropped: the sequence is not restarted and overrun is set to 1. overrun is cleared only by reset.
- Arithmetic is unsigned, width-preserving. Inputs outside 0..X_MAX/0..Y_MAX are out of contract.

Test Plan:
- NUM_AGENTS=4; agent0 (2,1) RIGHT, map_q=0, others WAIT; tick at T -> upd_valid at T+3 with id 0, (3,1), blocked 0. Ids 1,2,3 at T+5/T+7/T+9 with unchanged tiles; done at T+9; busy high T+1..T+8.
- Agent0 (2,1) UP; the bench returns map_q=1 when map=(2,2) -> map_x=2, map_y=2 during ADDR at T+1; upd (2,1), blocked 1.
- Wrap cases with map_q forced to 1: (26,5) RIGHT -> (0,5); (0,5) LEFT -> (26,5); (4,23) UP -> (4,0); (4,0) DOWN -> (4,23); all blocked 0.
- agent_dir=6 for agent 2 at (10,10) -> upd id 2, (10,10), blocked 0. Change agent_x after T -> committed values unaffected.
- Tick again at T+4 -> overrun=1 and remains 1; exactly 4 upd_valid pulses; a new tick at T+9 is accepted, with upd_valid at T+12.
- reset_n low at T+4 -> from T+5 all outputs 0, state IDLE, no further upd_valid/done; a tick after reset is released -> normal sequence.
